// File: rtl/alu_writeback_if.sv
// Handshake bundle between the ALU, the writeback buffer and the register file.
// The slave modport is the writeback block's view; master is the driver's view.
interface alu_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_y;
    logic        alu_c;
    logic        alu_n;
    logic        alu_z;
    logic [2:0]  dest;
    logic        flag_we;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic [2:0]  out_dest;
    logic [2:0]  status;
    logic [2:0]  cond_sel;
    logic        cond_true;

    modport slave (
        input  in_valid, alu_y, alu_c, alu_n, alu_z, dest, flag_we, out_ready, cond_sel,
        output in_ready, out_valid, out_y, out_dest, status, cond_true
    );

    modport master (
        output in_valid, alu_y, alu_c, alu_n, alu_z, dest, flag_we, out_ready, cond_sel,
        input  in_ready, out_valid, out_y, out_dest, status, cond_true
    );
endinterface

// File: rtl/alu_writeback.sv
// ALU result writeback buffer with status flags and branch-condition decode.
// Define WB_SKID_BUFFER_EN for a two-entry skid buffer with a registered in_ready.
module alu_writeback (
    input logic          clk,
    input logic          reset,
    alu_writeback_if.slave wb
);

    logic        in_ready;
    logic        accept;
    logic        drain;

    logic        out_valid_q, out_valid_d;
    logic [15:0] out_y_q, out_y_d;
    logic [2:0]  out_dest_q, out_dest_d;
    logic [2:0]  status_q, status_d;

    assign accept = wb.in_valid && in_ready;
    assign drain  = out_valid_q && wb.out_ready;

`ifdef WB_SKID_BUFFER_EN
    logic        skid_valid_q, skid_valid_d;
    logic [15:0] skid_y_q, skid_y_d;
    logic [2:0]  skid_dest_q, skid_dest_d;
    logic        in_ready_q;

    assign in_ready = in_ready_q;

    // Skid is only ever occupied while the output entry is full.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_y_d      = out_y_q;
        out_dest_d   = out_dest_q;
        skid_valid_d = skid_valid_q;
        skid_y_d     = skid_y_q;
        skid_dest_d  = skid_dest_q;
        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_y_d      = skid_y_q;
                out_dest_d   = skid_dest_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_y_d     = wb.alu_y;
                out_dest_d  = wb.dest;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_y_d     = wb.alu_y;
            skid_dest_d  = wb.dest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_y_q     <= 16'h0000;
            skid_dest_q  <= 3'b000;
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_y_q     <= skid_y_d;
            skid_dest_q  <= skid_dest_d;
            in_ready_q   <= !skid_valid_d;
        end
    end
`else
    assign in_ready = !out_valid_q || wb.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_dest_d  = out_dest_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_y_d     = wb.alu_y;
            out_dest_d  = wb.dest;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // Flags follow acceptance only; drain timing never affects them.
    always_comb begin
        status_d = status_q;
        if (accept && wb.flag_we) begin
            status_d = {wb.alu_c, wb.alu_n, wb.alu_z};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_y_q     <= 16'h0000;
            out_dest_q  <= 3'b000;
            status_q    <= 3'b000;
        end else begin
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_dest_q  <= out_dest_d;
            status_q    <= status_d;
        end
    end

    always_comb begin
        wb.cond_true = 1'b0;
        case (wb.cond_sel)
            3'b000:  wb.cond_true = 1'b1;
            3'b001:  wb.cond_true = status_q[0];
            3'b010:  wb.cond_true = !status_q[0];
            3'b011:  wb.cond_true = status_q[2];
            3'b100:  wb.cond_true = !status_q[2];
            3'b101:  wb.cond_true = status_q[1];
            3'b110:  wb.cond_true = !status_q[1];
            default: wb.cond_true = 1'b0;
        endcase
    end

    assign wb.in_ready  = in_ready;
    assign wb.out_valid = out_valid_q;
    assign wb.out_y     = out_y_q;
    assign wb.out_dest  = out_dest_q;
    assign wb.status    = status_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback; expectations follow WB_SKID_BUFFER_EN.
module tb_alu_writeback;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_writeback_if wb ();

    alu_writeback dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [15:0] y, input logic [2:0] d,
                         input logic [2:0] cnz, input logic fwe);
        wb.in_valid = v;
        wb.alu_y    = y;
        wb.dest     = d;
        {wb.alu_c, wb.alu_n, wb.alu_z} = cnz;
        wb.flag_we  = fwe;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0);
        wb.out_ready = 1'b0;
        wb.cond_sel  = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (wb.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", wb.out_valid); end
        checks++; if (wb.out_y !== 16'h0000) begin errors++; $display("FAIL reset_out_y: got %h want 0000", wb.out_y); end
        checks++; if (wb.out_dest !== 3'd0) begin errors++; $display("FAIL reset_out_dest: got %0d want 0", wb.out_dest); end
        checks++; if (wb.status !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", wb.status); end
        checks++; if (wb.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", wb.in_ready); end
    endtask

    task automatic test_single();
        wb.out_ready = 1'b1;
        drive(1'b1, 16'h1234, 3'd5, 3'b000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0);
        checks++; if (wb.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", wb.out_valid); end
        checks++; if (wb.out_y !== 16'h1234) begin errors++; $display("FAIL single_y: got %h want 1234", wb.out_y); end
        checks++; if (wb.out_dest !== 3'd5) begin errors++; $display("FAIL single_dest: got %0d want 5", wb.out_dest); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (wb.out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", wb.out_valid); end
    endtask

    task automatic test_flags();
        wb.out_ready = 1'b1;
        drive(1'b1, 16'h0010, 3'd1, 3'b101, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 16'h0020, 3'd2, 3'b010, 1'b0);
        checks++; if (wb.status !== 3'b101) begin errors++; $display("FAIL flags_status: got %b want 101", wb.status); end
        wb.cond_sel = 3'b001; #1;
        checks++; if (wb.cond_true !== 1'b1) begin errors++; $display("FAIL flags_cond_z: got %b want 1", wb.cond_true); end
        wb.cond_sel = 3'b010; #1;
        checks++; if (wb.cond_true !== 1'b0) begin errors++; $display("FAIL flags_cond_nz: got %b want 0", wb.cond_true); end
        wb.cond_sel = 3'b011; #1;
        checks++; if (wb.cond_true !== 1'b1) begin errors++; $display("FAIL flags_cond_c: got %b want 1", wb.cond_true); end
        wb.cond_sel = 3'b101; #1;
        checks++; if (wb.cond_true !== 1'b0) begin errors++; $display("FAIL flags_cond_n: got %b want 0", wb.cond_true); end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0);
        checks++; if (wb.status !== 3'b101) begin errors++; $display("FAIL flags_hold: got %b want 101", wb.status); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_cond_sweep();
        logic [7:0] exp;
        exp = 8'b0101_0101;
        wb.out_ready = 1'b1;
        drive(1'b1, 16'h0030, 3'd3, 3'b000, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0);
        checks++; if (wb.status !== 3'b000) begin errors++; $display("FAIL sweep_status: got %b want 000", wb.status); end
        for (int i = 0; i < 8; i++) begin
            wb.cond_sel = 3'(i);
            #1;
            checks++; if (wb.cond_true !== exp[i]) begin errors++; $display("FAIL sweep_cond%0d: got %b want %b", i, wb.cond_true, exp[i]); end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        wb.out_ready = 1'b0;
        drive(1'b1, 16'h0001, 3'd1, 3'b000, 1'b0);
        checks++; if (wb.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b want 1", wb.in_ready); end
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 16'h0002, 3'd2, 3'b000, 1'b0);
`ifdef WB_SKID_BUFFER_EN
        checks++; if (wb.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b: got %b want 1", wb.in_ready); end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0);
`else
        checks++; if (wb.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_b: got %b want 0", wb.in_ready); end
        @(posedge clk);
        @(negedge clk);
`endif
        checks++; if (wb.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", wb.in_ready); end
        checks++; if (wb.out_y !== 16'h0001) begin errors++; $display("FAIL bp_hold_y: got %h want 0001", wb.out_y); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (wb.out_y !== 16'h0001 || wb.out_dest !== 3'd1) begin errors++; $display("FAIL bp_stable: got %h/%0d want 0001/1", wb.out_y, wb.out_dest); end
        checks++; if (wb.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", wb.out_valid); end
        wb.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0);
        checks++; if (wb.out_valid !== 1'b1 || wb.out_y !== 16'h0002 || wb.out_dest !== 3'd2) begin errors++; $display("FAIL bp_second: got %b/%h/%0d want 1/0002/2", wb.out_valid, wb.out_y, wb.out_dest); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (wb.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", wb.out_valid); end
    endtask

    task automatic test_back_to_back();
        wb.out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                checks++; if (wb.out_valid !== 1'b1 || wb.out_y !== 16'h00A0 + 16'(i - 1) || wb.out_dest !== 3'(i - 1)) begin errors++; $display("FAIL b2b_%0d: got %b/%h/%0d want 1/%h/%0d", i - 1, wb.out_valid, wb.out_y, wb.out_dest, 16'h00A0 + 16'(i - 1), i - 1); end
            end
            if (i < 8) begin
                drive(1'b1, 16'h00A0 + 16'(i), 3'(i), 3'b000, 1'b0);
                checks++; if (wb.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", i, wb.in_ready); end
            end else begin
                drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++; if (wb.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", wb.out_valid); end
    endtask

    task automatic test_reset_mid();
        wb.out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 3'd6, 3'b111, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 16'hBBBB, 3'd7, 3'b111, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checks++; if (wb.status !== 3'b111) begin errors++; $display("FAIL mid_status_pre: got %b want 111", wb.status); end
        reset = 1'b1;
        wb.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0);
        checks++; if (wb.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", wb.out_valid); end
        checks++; if (wb.status !== 3'b000) begin errors++; $display("FAIL mid_status: got %b want 000", wb.status); end
        checks++; if (wb.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", wb.in_ready); end
        checks++; if (wb.out_y !== 16'h0000) begin errors++; $display("FAIL mid_y: got %h want 0000", wb.out_y); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (wb.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_drain: got %b want 0", wb.out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_flags();
        test_cond_sweep();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
